time_entry: RTL
===============

# time_entry

Button-driven time-setting front end for the alarm clock. It takes the three raw push-buttons (select, increment, go), then synchronizes, debounces and edge-detects them. A small FSM lets the user edit a 4-digit BCD MM:SS setpoint. On commit it hands the value to the countdown controller with a one-cycle load pulse. It is the writer side of the controller's time-load interface; the controller's busy flag gates it.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; all state is cleared on the clk edge where reset=1.
- btnSel  in  1  raw, active-low, asynchronous: enter edit / advance the selected digit.
- btnInc  in  1  raw, active-low, asynchronous: increment the selected digit.
- btnGo  in  1  raw, active-low, asynchronous: commit the setpoint.
- busy  in  1  from the controller; high while a countdown or alarm is active.
- setTime  out  16  committed setpoint, BCD {m10,m1,s10,s1}.
- loadTime  out  1  one-cycle pulse; setTime is valid and new in that cycle.
- editTime  out  16  working value shown on the display while editing, same BCD layout.
- digitSel  out  2  digit being edited: 3=m10, 2=m1, 1=s10, 0=s1.
- editing  out  1  high in EDIT; the display blinks digitSel only when this is high.

## Operation
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: increments while the synced level differs from the debounced level. It clears on any match. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A press event is a registered 1-cycle pulse on the debounced released→pressed transition. A hold gives exactly one event. Releases give no event. Glitches shorter than DEBOUNCE_CYCLES give no event.
- Event priority in the same cycle: go > inc > sel. Only the highest-priority event is acted on; the others are dropped.
- FSM states: IDLE, EDIT, COMMIT.
  - IDLE: editing=0.
    - sel event with busy=0 → EDIT, editTime←setTime, digitSel←3.
    - inc and go events are ignored. sel with busy=1 is ignored.
  - EDIT: editing=1.
    - sel event → digitSel decrements, wrapping 0→3.
    - inc event → the selected digit increments with wrap: m10 9→0, m1 9→0, s10 5→0, s1 9→0. Other digits are unchanged; there is no carry.
    - go event → COMMIT.
    - busy=1 in any EDIT cycle → IDLE (abort). editTime is discarded and setTime is unchanged; this has precedence over events in the same cycle.
  - COMMIT: one cycle, then → IDLE.
    - If editTime≠0000: setTime←editTime and loadTime=1 this cycle.
    - If editTime=0000: no load and setTime is unchanged.
- editTime holds its value in IDLE.
- setTime changes only in COMMIT or on reset.

## Timing
- Reset values:
  - setTime=0000, editTime=0000, loadTime=0, digitSel=3, editing=0, state=IDLE.
  - Debounced levels=released, counters=0, synchronizers=released (1).
- Press latency: a raw button held low from edge N produces its event pulse on edge N+DEBOUNCE_CYCLES+2. The resulting state, editTime or digitSel update is visible after edge N+DEBOUNCE_CYCLES+3.
- loadTime: asserted for exactly one cycle, the cycle after the go event. setTime carries the new value from the same edge, and loadTime is never asserted on back-to-back cycles.
- Reset mid-operation (any state, a debounce in progress, or a button still held): everything returns to reset values. A button still held through reset produces a new event once it has been debounced, DEBOUNCE_CYCLES+2 edges after reset deasserts.
- busy is sampled every cycle and is not debounced.

## Test plan
(DEBOUNCE_CYCLES=4 in all scenarios.)
- Reset, then btnSel low for 10 cycles → editing=1 with digitSel=3 after exactly 7 edges; no loadTime; setTime=0000.
- btnInc glitch low for 3 cycles in EDIT → no editTime change. A later 20-cycle hold → exactly one increment.
- Entry 12:59:
  - sel into EDIT; inc×1 (m10=1); sel; inc×2 (m1=2); sel; inc×5 (s10=5); sel; inc×9 (s1=9).
  - go → single loadTime pulse with setTime=16'h1259, then editing=0.
  - Further inc presses on s10 from 5 wrap it to 0.
- go with editTime=0000 → no loadTime, return to IDLE. sel with busy=1 in IDLE → stays in IDLE.
- busy raised in EDIT after editTime=16'h0300 → IDLE next cycle, setTime unchanged. Re-entry shows editTime=setTime.
- Same-cycle go and inc events → commit only; the inc is dropped. reset asserted during COMMIT → loadTime=0 and setTime=0000 on the next edge.

Source files
------------

// File: rtl/time_entry.sv
// rtl/time_entry.sv - button-driven MM:SS setpoint entry with debounced inputs and commit pulse
// Writer side of the countdown controller's time-load interface.

module time_entry_btn #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          s1, s2, level, level_d;
  logic [CW-1:0] cnt;

  // Buttons are active-low: level 1 means released.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
      press   <= level_d & ~level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module time_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnSel,
  input  logic        btnInc,
  input  logic        btnGo,
  input  logic        busy,
  output logic [15:0] setTime,
  output logic        loadTime,
  output logic [15:0] editTime,
  output logic [1:0]  digitSel,
  output logic        editing
);
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t      state, state_n;
  logic        sel_p, inc_p, go_p;
  logic        ev_sel, ev_inc, ev_go;
  logic [15:0] edit_n, set_n;
  logic [1:0]  dig_n;
  logic        load_n;
  logic [3:0]  nib, nib_max, nib_inc;

  time_entry_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_sel (.clk(clk), .reset(reset), .raw(btnSel), .press(sel_p));
  time_entry_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_inc (.clk(clk), .reset(reset), .raw(btnInc), .press(inc_p));
  time_entry_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_go  (.clk(clk), .reset(reset), .raw(btnGo),  .press(go_p));

  assign ev_go  = go_p;
  assign ev_inc = inc_p & ~go_p;
  assign ev_sel = sel_p & ~inc_p & ~go_p;

  // Tens-of-seconds wraps after 5; every other digit after 9, with no carry.
  always_comb begin
    nib     = editTime[{digitSel, 2'b00} +: 4];
    nib_max = (digitSel == 2'd1) ? 4'd5 : 4'd9;
    nib_inc = (nib >= nib_max) ? 4'd0 : nib + 4'd1;
  end

  always_comb begin
    state_n = state;
    edit_n  = editTime;
    set_n   = setTime;
    dig_n   = digitSel;
    load_n  = 1'b0;
    case (state)
      IDLE: begin
        if (ev_sel && !busy) begin
          state_n = EDIT;
          edit_n  = setTime;
          dig_n   = 2'd3;
        end
      end
      EDIT: begin
        if (busy) begin
          state_n = IDLE;
        end else if (ev_go) begin
          state_n = COMMIT;
          if (editTime != 16'h0000) begin
            set_n  = editTime;
            load_n = 1'b1;
          end
        end else if (ev_inc) begin
          edit_n[{digitSel, 2'b00} +: 4] = nib_inc;
        end else if (ev_sel) begin
          dig_n = digitSel - 2'd1;
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      setTime  <= 16'h0000;
      editTime <= 16'h0000;
      digitSel <= 2'd3;
      loadTime <= 1'b0;
    end else begin
      state    <= state_n;
      setTime  <= set_n;
      editTime <= edit_n;
      digitSel <= dig_n;
      loadTime <= load_n;
    end
  end

  assign editing = (state == EDIT);
endmodule
